bpred_update_ctrl: RTL
======================

BPRED_UPDATE_CTRL -- requirements
Module: bpred_update_ctrl

Interface
REQ-001: Parameter QDEPTH, default 4, resolved-branch queue depth in entries.
REQ-002: Parameter IDXW, default 8, width of the direction-table index.
REQ-003: clk  in  1  single clock; all state updates on its rising edge.
REQ-004: reset  in  1  asynchronous, active-high reset.
REQ-005: res_valid  in  1  a resolved branch is offered.
REQ-006: res_ready  out  1  queue can accept an entry this cycle.
REQ-007: res_pc  in  32  PC of the resolved branch.
REQ-008: res_target  in  32  resolved target address.
REQ-009: res_taken  in  1  resolved direction, 1 = taken.
REQ-010: flush  in  1  synchronous discard of all pending updates.
REQ-011: fetch_busy  in  1  fetch owns the direction-table port this cycle.
REQ-012: tbl_addr  out  IDXW  direction-table index, equal to head pc[IDXW+1:2].
REQ-013: tbl_rden  out  1  direction-table read strobe.
REQ-014: tbl_rdata  in  2  counter value, valid the cycle after tbl_rden.
REQ-015: tbl_wren  out  1  direction-table write strobe.
REQ-016: tbl_wdata  out  2  updated counter value.
REQ-017: btb_wren  out  1  BTB write strobe.
REQ-018: btb_w_addr  out  32  BTB write address, equal to head pc.
REQ-019: btb_w_data  out  32  BTB write data, equal to head target.
REQ-020: q_count  out  clog2(QDEPTH)+1  number of queued entries.

Function
REQ-021: Queue is a FIFO of {pc, target, taken}; push occurs when res_valid and res_ready are both 1.
REQ-022: res_ready = (q_count < QDEPTH); it is combinational from the count and does not depend on a same-cycle pop.
REQ-023: A push and a pop in the same cycle leave q_count unchanged; pointers wrap modulo QDEPTH.
REQ-024: The FSM has three states: IDLE, READ, WRITE.
REQ-025: IDLE: when q_count != 0 and fetch_busy = 0, assert tbl_rden for one cycle and go to READ; otherwise stay in IDLE with tbl_rden = 0.
REQ-026: READ: latch tbl_rdata and compute the new counter; taken gives min(c+1, 3), not-taken gives max(c-1, 0); go to WRITE.
REQ-027: WRITE: when fetch_busy = 0, assert tbl_wren with the latched new counter, pop the head, and go to IDLE; when fetch_busy = 1, hold in WRITE with the value retained and no strobes asserted.
REQ-028: btb_wren is asserted in the same cycle as tbl_wren only when the head taken bit = 1; not-taken branches never write the BTB.
REQ-029: tbl_rden, tbl_wren and btb_wren are never asserted while fetch_busy = 1, and never more than one table strobe is asserted per cycle.
REQ-030: Minimum service time is 3 cycles per entry (IDLE, READ, WRITE); back-to-back entries are never overlapped.
REQ-031: tbl_addr, btb_w_addr and btb_w_data always reflect the queue head; their values are don't-care when the queue is empty.
REQ-032: flush empties the queue, forces the FSM to IDLE and suppresses all strobes in that cycle; an in-progress update is abandoned; a res_valid in the same cycle is dropped.

Reset
REQ-033: While reset is asserted, FSM = IDLE, q_count = 0, res_ready = 1 and tbl_rden = tbl_wren = btb_wren = 0, independent of clk.
REQ-034: Reset asserted mid-update abandons that update without writing; after reset deassertion, operation begins from IDLE on the next rising edge.

Verification
REQ-035: Push {pc=0x40, target=0x80, taken=1} with tbl_rdata=1 -> tbl_rden at t+1 with tbl_addr=0x10; tbl_wren with wdata=2 plus btb_wren with addr=0x40, data=0x80 at t+3.
REQ-036: Push taken=0 with tbl_rdata=0 -> tbl_wdata=0 and btb_wren stays 0; taken=1 with tbl_rdata=3 -> tbl_wdata=3.
REQ-037: Push 5 entries back-to-back with no drain (fetch_busy=1) -> res_ready=0 after the 4th push, q_count=4, the 5th entry is not accepted.
REQ-038: Hold fetch_busy=1 during WRITE for 3 cycles -> no strobes; tbl_wren fires on the first cycle with fetch_busy=0 with the unchanged value.
REQ-039: Assert flush with 3 entries queued while in READ -> q_count=0 next cycle, no tbl_wren or btb_wren, FSM back in IDLE.
REQ-040: Assert reset asynchronously between edges while in WRITE -> outputs clear immediately and q_count=0; the pending entry is never written.

Source files
------------

// File: rtl/bpred_update_ctrl.sv
// Branch-predictor update controller: queues resolved branches and retires them
// one at a time as a read-modify-write of the 2-bit direction counter plus a BTB write.
module bpred_update_ctrl #(
    parameter int QDEPTH = 4,
    parameter int IDXW   = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      res_valid,
    output logic                      res_ready,
    input  logic [31:0]               res_pc,
    input  logic [31:0]               res_target,
    input  logic                      res_taken,
    input  logic                      flush,
    input  logic                      fetch_busy,
    output logic [IDXW-1:0]           tbl_addr,
    output logic                      tbl_rden,
    input  logic [1:0]                tbl_rdata,
    output logic                      tbl_wren,
    output logic [1:0]                tbl_wdata,
    output logic                      btb_wren,
    output logic [31:0]               btb_w_addr,
    output logic [31:0]               btb_w_data,
    output logic [$clog2(QDEPTH):0]   q_count
);
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH) + 1;

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        tkn;
    } entry_t;

    entry_t        fifo_q [QDEPTH];
    entry_t        head;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    ctr_q, ctr_d;
    state_e        state_q, state_d;
    logic          push, pop;

    assign head      = fifo_q[rd_ptr_q];
    assign res_ready = (cnt_q < CW'(QDEPTH));
    assign push      = res_valid && res_ready && !flush;
    assign pop       = tbl_wren;

    assign q_count    = cnt_q;
    assign tbl_addr   = head.pc[IDXW+1:2];
    assign btb_w_addr = head.pc;
    assign btb_w_data = head.tgt;
    assign tbl_wdata  = ctr_q;

    // ---------------- queue ----------------
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= '{pc: res_pc, tgt: res_target, tkn: res_taken};
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) wr_ptr_d = (wr_ptr_q == PW'(QDEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = (rd_ptr_q == PW'(QDEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Saturating counter update, captured while the table data is on tbl_rdata.
    always_comb begin
        ctr_d = ctr_q;
        if (state_q == READ) begin
            if (head.tkn) ctr_d = (tbl_rdata == 2'd3) ? 2'd3 : tbl_rdata + 2'd1;
            else          ctr_d = (tbl_rdata == 2'd0) ? 2'd0 : tbl_rdata - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ctr_q <= 2'd0;
        else       ctr_q <= ctr_d;
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (cnt_q != '0 && !fetch_busy) state_d = READ;
                READ:    state_d = WRITE;
                WRITE:   if (!fetch_busy) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        tbl_rden = 1'b0;
        tbl_wren = 1'b0;
        btb_wren = 1'b0;
        if (!flush) begin
            case (state_q)
                IDLE:  tbl_rden = (cnt_q != '0) && !fetch_busy;
                WRITE: begin
                    tbl_wren = !fetch_busy;
                    btb_wren = !fetch_busy && head.tkn;
                end
                default: ;
            endcase
        end
    end
endmodule
